// File: rtl/md_unit.sv
// HI/LO multiply-divide unit for the EX stage: fixed-latency MULT/MULTU/DIV/DIVU
// plus single-cycle MTHI/MTLO, with Busy exported to the hazard unit.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] opA_q, opA_d;
    logic [31:0] opB_q, opB_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        finish;
    logic        signedOp;
    logic        divZero;
    logic [31:0] extHi, extHiB;
    logic [63:0] product;
    logic [31:0] absA, absB, divisor, uQuot, uRem, quot, rem;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        case (state_q)
            IDLE: begin
                if (Start && !MDOp[2]) begin
                    state_d = RUN;
                    count_d = MDOp[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    op_d    = MDOp[1:0];
                    opA_d   = A;
                    opB_d   = B;
                end
            end
            RUN: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One 64-bit multiplier serves both signednesses: the low 64 bits of the
    // product of the extended operands are the same either way.
    always_comb begin
        signedOp = ~op_q[0];
        extHi    = (signedOp && opA_q[31]) ? 32'hFFFF_FFFF : 32'h0;
        extHiB   = (signedOp && opB_q[31]) ? 32'hFFFF_FFFF : 32'h0;
        product  = {extHi, opA_q} * {extHiB, opB_q};

        divZero = (opB_q == 32'h0);
        absA    = (signedOp && opA_q[31]) ? -opA_q : opA_q;
        absB    = (signedOp && opB_q[31]) ? -opB_q : opB_q;
        divisor = divZero ? 32'h1 : absB;
        uQuot   = absA / divisor;
        uRem    = absA % divisor;
        quot    = (signedOp && (opA_q[31] ^ opB_q[31])) ? -uQuot : uQuot;
        rem     = (signedOp && opA_q[31]) ? -uRem : uRem;
    end

    assign finish = (state_q == RUN) && (count_q == 4'd1);

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == IDLE && Start) begin
            if (MDOp == 3'd4) hi_d = A;
            if (MDOp == 3'd5) lo_d = A;
        end else if (finish) begin
            if (!op_q[1]) begin
                hi_d = product[63:32];
                lo_d = product[31:0];
            end else if (!divZero) begin
                hi_d = rem;
                lo_d = quot;
            end
        end
    end

    assign Busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the two operands read from the register file and forwarded through ID/EX.
- Executes MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency and holds the results in the architectural HI/LO registers; also performs MTHI/MTLO writes.
- Exports Busy so the hazard unit stalls later HI/LO-touching instructions in ID.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU (legal range 1..15)

Ports:
- Clk  input  1  clock; all state updates on posedge
- Rst  input  1  reset, synchronous, active-high
- Start  input  1  launch MDOp with operands A/B this cycle
- MDOp  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
- A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO data)
- B  input  32  operand rt (divisor / multiplier)
- Busy  output  1  operation in progress
- HI  output  32  HI register value
- LO  output  32  LO register value

Behaviour:
- Reset, checked at posedge Rst=1 and taking priority over all else:
  - HI=0, LO=0, Busy=0, internal cycle counter=0.
  - Any pending operation is discarded.
  - Mid-operation reset: results are never written; Busy=0 from the next cycle.
- Idle state (Busy=0):
  - A posedge with Start=1 and MDOp in 0..3 latches A, B and MDOp internally. Busy=1 from the following cycle.
  - A/B may change after the launch edge without affecting the result.
  - Counter loads MULT_CYCLES for ops 0..1 and DIV_CYCLES for ops 2..3.
- Busy state:
  - Counter decrements each posedge.
  - On the posedge where the counter reaches 0:
    - HI/LO load the result.
    - Busy drops to 0.
  - Busy is therefore high for exactly N cycles after the launch edge.
  - HI/LO hold their old values throughout Busy and change only at completion.
- States: IDLE -> (Start & op 0..3) -> RUN(N) -> completion -> IDLE. No back-to-back overlap.
- Start while Busy=1: ignored entirely, for any MDOp including MTHI/MTLO.
  - The hazard unit guarantees this does not happen; the block must not corrupt state if it does.
- MTHI/MTLO (Start=1, op 4/5, Busy=0):
  - HI or LO = A at that posedge; the other register is unchanged.
  - Busy stays 0 (single cycle).
- MDOp 6/7 with Start=1: no effect.
- Start=0: no effect regardless of MDOp.
- MULT: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0].
- MULTU: unsigned 32x32 -> 64; same HI/LO split.
- DIV (signed):
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU: unsigned; LO = quotient, HI = remainder.
- Divide by zero (B=0, DIV or DIVU):
  - Busy runs the full DIV_CYCLES.
  - HI and LO retain their prior values at completion.
- Result computation may be a single-cycle combinational op on the latched operands, registered at completion. An iterative datapath is not required.
- Outputs HI, LO, Busy are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Rst=1 one edge after arbitrary activity, including mid-DIV -> HI=0, LO=0, Busy=0 next cycle; no late HI/LO update.
- MULT A=0xFFFFFFFD (-3), B=5 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. HI/LO unchanged during Busy.
- MULTU A=B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=7, B=2 -> LO=3, HI=1.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIVU B=0 -> Busy 10 cycles; HI=0x11, LO=0x22 afterwards.
- During MULT Busy, pulse Start with MTLO A=0xDEAD and with DIV -> both ignored; final HI/LO equal the MULT result; Busy falls on schedule.
- MTHI A=0x1234 when idle -> HI=0x1234 next cycle, LO unchanged, Busy never rises.
